mbinit_param_responder: RTL and testbench
=========================================

Name: mbinit_param_responder

Overview:
- Partner-side responder for the MBINIT.PARAM exchange.
- Waits for the remote MBINIT_PARAM_configuration_req, latches the advertised parameters, and resolves them against local capability (max data rate, clock mode, clock phase).
- Returns MBINIT_PARAM_configuration_resp with the resolved values through the sideband TX path.
- Sits alongside the PARAM initiator under the MBINIT controller. Both must end before MBINIT advances.

Parameters:
- TIMEOUT_CYCLES, 800000, cycles allowed in WAIT_REQ before error (8 ms at 100 MHz).
- TO_W, 20, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  block clock
- rst  in  1  asynchronous reset, active-high
- i_MBINIT_Start_en  in  1  enable from MBINIT controller; low forces IDLE
- i_RX_SbMessage  in  4  decoded RX sideband message code
- i_msg_valid  in  1  i_RX_SbMessage and RX fields valid this cycle
- i_RX_VoltageSwing  in  5  partner TX swing field of the req
- i_RX_MaxDataRate  in  3  partner max data rate field of the req
- i_RX_ClockMode  in  1  requested clock mode (0 strobe, 1 continuous)
- i_RX_PhaseClock  in  1  requested clock phase (0 differential, 1 quadrature)
- i_Local_MaxDataRate  in  3  local max rate capability, static during MBINIT
- i_Local_ContClk_Support  in  1  local supports continuous clock
- i_Local_Quad_Support  in  1  local supports quadrature phase
- i_Busy_SideBand  in  1  sideband TX busy
- i_falling_edge_busy  in  1  one-cycle pulse when the sideband finished sending
- o_TX_SbMessage  out  4  message code to sideband TX
- o_ValidOutDatat_Module  out  1  TX message valid
- o_ValidDataFieldParameters  out  1  TX data field carries parameters
- o_TX_MaxDataRate  out  3  resolved rate in the resp
- o_TX_ClockMode  out  1  resolved clock mode in the resp
- o_TX_PhaseClock  out  1  resolved phase in the resp
- o_RX_VoltageSwing_Latched  out  5  partner swing, held after capture
- o_MBINIT_PARAM_Resp_end  out  1  resp sent; level held in DONE
- o_train_error_req  out  1  one-cycle error pulse

Behaviour:
- Message codes: configuration_req = 4'b0001, configuration_resp = 4'b0010.
- Reset: all outputs 0, state IDLE, latches 0, timeout counter 0.
- All outputs are registered and decoded from the next state (NS), matching the initiator timing.
- FSM states: IDLE, WAIT_REQ, RESOLVE, SEND_RESP, DONE, ERROR.
- IDLE -> WAIT_REQ when i_MBINIT_Start_en=1.
- In every non-IDLE state, i_MBINIT_Start_en=0 -> IDLE next cycle, and all outputs return to 0 on the following edge.
- WAIT_REQ:
  - Timeout counter increments each cycle.
  - i_msg_valid && code==req: latch the four RX fields -> RESOLVE. The counter clears.
  - Any other code is ignored.
  - Counter reaches TIMEOUT_CYCLES-1 with no req: -> ERROR.
  - A req arriving on the same cycle as the timeout wins; no error is raised.
- RESOLVE (exactly 1 cycle):
  - rate = min(latched rate, i_Local_MaxDataRate).
  - mode = latched ClockMode & i_Local_ContClk_Support.
  - phase = latched PhaseClock & i_Local_Quad_Support.
  - rate==0 -> ERROR; otherwise -> SEND_RESP.
- SEND_RESP:
  - Outputs are driven only while i_Busy_SideBand=0 at the decision cycle; otherwise the state is held with outputs 0 until busy drops.
  - When driven: o_ValidOutDatat_Module=1, o_ValidDataFieldParameters=1, o_TX_SbMessage=resp, plus the resolved fields.
  - The driven outputs hold until i_falling_edge_busy -> DONE.
- Latency: req valid at edge N -> RESOLVE at N+1 -> resp outputs visible after edge N+2 when the sideband is idle.
- DONE:
  - o_MBINIT_PARAM_Resp_end=1 (level).
  - A repeated valid req is re-latched -> RESOLVE, and resp_end drops. This covers a partner retry.
- ERROR:
  - o_train_error_req pulses for exactly 1 cycle on entry.
  - The state then holds with all outputs 0 until i_MBINIT_Start_en=0.
- o_RX_VoltageSwing_Latched updates only on req capture and clears on entry to IDLE.
- An asynchronous reset mid-transfer drops valid immediately. The sideband owner discards any partial message.

Decomposition:
- Shared package mbinit_pkg holds:
  - the sideband message code localparams (shared with the initiator);
  - the clock mode and phase encodings;
  - the data rate encoding, where 0 = invalid.
- One sub-module, param_resolver: purely combinational min/AND resolution plus a no_common_rate flag. It is reusable by the initiator's checker.
- The FSM and counters stay in the top module.

Test Plan:
- Nominal: start_en=1; req with rate 5, mode 1, phase 1; local 3/1/0; busy=0 -> at N+2 resp is valid with code 2, rate 3, mode 1, phase 0; after a falling_edge_busy pulse, resp_end=1.
- Busy hold: repeat nominal with busy=1 for 10 cycles after RESOLVE -> valid stays 0 for those cycles; it asserts the cycle after busy drops; rate=3.
- No common rate: req rate 0 -> one o_train_error_req pulse at N+2; resp is never sent; return to IDLE only after start_en=0.
- Timeout: TIMEOUT_CYCLES=16, no req -> error pulse exactly 16 cycles after entering WAIT_REQ. Separately, a req on cycle 15 -> no error and a resp is sent.
- Abort and retry:
  - Drop start_en during SEND_RESP -> all outputs 0 within 2 cycles and the state reaches IDLE.
  - A second req while in DONE -> resp_end drops and a new resp is sent carrying the new resolved rate.
- Async reset: assert rst mid-SEND_RESP between clock edges -> outputs 0 immediately; after release, the state is IDLE.

Source files
------------

// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes, clock mode/phase and data rate
// encodings, the parameter payload struct and the PARAM responder state encoding.
package mbinit_pkg;

  localparam int unsigned MSG_W   = 4;
  localparam int unsigned RATE_W  = 3;
  localparam int unsigned SWING_W = 5;

  // Sideband message codes, common to the PARAM initiator and responder.
  localparam logic [MSG_W-1:0] MSG_PARAM_CFG_REQ  = 4'b0001;
  localparam logic [MSG_W-1:0] MSG_PARAM_CFG_RESP = 4'b0010;

  // Clock mode / phase encodings.
  localparam logic CLK_MODE_STROBE = 1'b0;
  localparam logic CLK_MODE_CONT   = 1'b1;
  localparam logic CLK_PHASE_DIFF  = 1'b0;
  localparam logic CLK_PHASE_QUAD  = 1'b1;

  // Data rate encoding; zero means no usable rate.
  localparam logic [RATE_W-1:0] RATE_INVALID = 3'd0;

  // Negotiated link parameters as carried in the req/resp data field.
  typedef struct packed {
    logic [RATE_W-1:0] rate;
    logic              clk_mode;
    logic              clk_phase;
  } mb_param_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_REQ  = 3'd1,
    ST_RESOLVE   = 3'd2,
    ST_SEND_RESP = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } param_rsp_state_e;

endpackage

// File: rtl/param_resolver.sv
// Combinational resolution of partner-requested parameters against local capability.
//   req_i              : parameters advertised by the partner
//   local_rate_i       : local max data rate
//   local_cont_clk_i   : local continuous clock support
//   local_quad_i       : local quadrature phase support
//   resolved_c_o       : min rate, AND-ed mode and phase
//   no_common_rate_c_o : resolved rate is the invalid encoding
module param_resolver
  import mbinit_pkg::*;
(
  input  mb_param_t         req_i,
  input  logic [RATE_W-1:0] local_rate_i,
  input  logic              local_cont_clk_i,
  input  logic              local_quad_i,
  output mb_param_t         resolved_c_o,
  output logic              no_common_rate_c_o
);

  // Highest common rate is the lower of the two capabilities.
  always_comb begin
    resolved_c_o.rate      = (req_i.rate < local_rate_i) ? req_i.rate : local_rate_i;
    resolved_c_o.clk_mode  = req_i.clk_mode & local_cont_clk_i;
    resolved_c_o.clk_phase = req_i.clk_phase & local_quad_i;
  end

  assign no_common_rate_c_o = (resolved_c_o.rate == RATE_INVALID);

endmodule

// File: rtl/mbinit_param_responder.sv
// Partner-side MBINIT.PARAM responder: waits for configuration_req, resolves the
// requested parameters against local capability and returns configuration_resp.
//   CLK, rst                    : clock, async active-high reset
//   i_MBINIT_Start_en           : enable; low returns to IDLE
//   i_RX_*, i_msg_valid         : decoded incoming sideband message and fields
//   i_Local_*                   : local capabilities (static during MBINIT)
//   i_Busy_SideBand             : sideband TX busy
//   i_falling_edge_busy         : sideband finished sending
//   o_TX_*, o_Valid*            : resp message towards sideband TX
//   o_RX_VoltageSwing_Latched   : partner swing captured from the req
//   o_MBINIT_PARAM_Resp_end     : resp delivered (level)
//   o_train_error_req           : single-cycle error pulse
// All outputs are registered and decoded from the next state.
module mbinit_param_responder
  import mbinit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned TO_W           = 20
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               i_MBINIT_Start_en,
  input  logic [MSG_W-1:0]   i_RX_SbMessage,
  input  logic               i_msg_valid,
  input  logic [SWING_W-1:0] i_RX_VoltageSwing,
  input  logic [RATE_W-1:0]  i_RX_MaxDataRate,
  input  logic               i_RX_ClockMode,
  input  logic               i_RX_PhaseClock,
  input  logic [RATE_W-1:0]  i_Local_MaxDataRate,
  input  logic               i_Local_ContClk_Support,
  input  logic               i_Local_Quad_Support,
  input  logic               i_Busy_SideBand,
  input  logic               i_falling_edge_busy,
  output logic [MSG_W-1:0]   o_TX_SbMessage,
  output logic               o_ValidOutDatat_Module,
  output logic               o_ValidDataFieldParameters,
  output logic [RATE_W-1:0]  o_TX_MaxDataRate,
  output logic               o_TX_ClockMode,
  output logic               o_TX_PhaseClock,
  output logic [SWING_W-1:0] o_RX_VoltageSwing_Latched,
  output logic               o_MBINIT_PARAM_Resp_end,
  output logic               o_train_error_req
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  param_rsp_state_e   state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  mb_param_t          req_q, req_d;
  logic [SWING_W-1:0] swing_q, swing_d;
  logic [MSG_W-1:0]   tx_msg_q, tx_msg_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_pvalid_q, tx_pvalid_d;
  mb_param_t          tx_param_q, tx_param_d;
  logic               resp_end_q, resp_end_d;
  logic               err_q, err_d;

  mb_param_t          resolved_c;
  logic               no_common_rate_c;
  logic               req_seen_c;

  assign req_seen_c = i_msg_valid && (i_RX_SbMessage == MSG_PARAM_CFG_REQ);

  param_resolver u_resolver (
    .req_i              (req_q),
    .local_rate_i       (i_Local_MaxDataRate),
    .local_cont_clk_i   (i_Local_ContClk_Support),
    .local_quad_i       (i_Local_Quad_Support),
    .resolved_c_o       (resolved_c),
    .no_common_rate_c_o (no_common_rate_c)
  );

  // Next-state, latch and next-state-decoded output logic.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = '0;
    req_d       = req_q;
    swing_d     = swing_q;
    tx_msg_d    = '0;
    tx_valid_d  = 1'b0;
    tx_pvalid_d = 1'b0;
    tx_param_d  = '0;
    resp_end_d  = 1'b0;
    err_d       = 1'b0;

    if ((state_q != ST_IDLE) && !i_MBINIT_Start_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_MBINIT_Start_en) state_d = ST_WAIT_REQ;
        end
        ST_WAIT_REQ: begin
          // A req on the final timeout cycle takes priority over the error.
          if (req_seen_c) begin
            state_d = ST_RESOLVE;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = ST_ERROR;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_RESOLVE: begin
          state_d = no_common_rate_c ? ST_ERROR : ST_SEND_RESP;
        end
        ST_SEND_RESP: begin
          // Only a completion of our own message counts.
          if (tx_valid_q && i_falling_edge_busy) state_d = ST_DONE;
        end
        ST_DONE: begin
          // Partner retry: re-resolve and answer again.
          if (req_seen_c) state_d = ST_RESOLVE;
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d == ST_RESOLVE) begin
      req_d.rate      = i_RX_MaxDataRate;
      req_d.clk_mode  = i_RX_ClockMode;
      req_d.clk_phase = i_RX_PhaseClock;
      swing_d         = i_RX_VoltageSwing;
    end else if (state_d == ST_IDLE) begin
      req_d   = '0;
      swing_d = '0;
    end

    unique case (state_d)
      ST_SEND_RESP: begin
        // Launch only into an idle sideband; once launched, hold until completion.
        if (tx_valid_q || !i_Busy_SideBand) begin
          tx_msg_d    = MSG_PARAM_CFG_RESP;
          tx_valid_d  = 1'b1;
          tx_pvalid_d = 1'b1;
          tx_param_d  = resolved_c;
        end
      end
      ST_DONE:  resp_end_d = 1'b1;
      ST_ERROR: err_d      = (state_q != ST_ERROR);
      default:  ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      req_q       <= '0;
      swing_q     <= '0;
      tx_msg_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_pvalid_q <= 1'b0;
      tx_param_q  <= '0;
      resp_end_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      req_q       <= req_d;
      swing_q     <= swing_d;
      tx_msg_q    <= tx_msg_d;
      tx_valid_q  <= tx_valid_d;
      tx_pvalid_q <= tx_pvalid_d;
      tx_param_q  <= tx_param_d;
      resp_end_q  <= resp_end_d;
      err_q       <= err_d;
    end
  end

  assign o_TX_SbMessage             = tx_msg_q;
  assign o_ValidOutDatat_Module     = tx_valid_q;
  assign o_ValidDataFieldParameters = tx_pvalid_q;
  assign o_TX_MaxDataRate           = tx_param_q.rate;
  assign o_TX_ClockMode             = tx_param_q.clk_mode;
  assign o_TX_PhaseClock            = tx_param_q.clk_phase;
  assign o_RX_VoltageSwing_Latched  = swing_q;
  assign o_MBINIT_PARAM_Resp_end    = resp_end_q;
  assign o_train_error_req          = err_q;

endmodule

// File: tb/tb_mbinit_param_responder.sv
// Directed bench for mbinit_param_responder: a transaction-level expectation model
// is checked against every output on every falling clock edge.
module tb_mbinit_param_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_en;
  logic [3:0] rx_msg;
  logic       msg_valid;
  logic [4:0] rx_swing;
  logic [2:0] rx_rate;
  logic       rx_mode, rx_phase;
  logic [2:0] loc_rate;
  logic       loc_cont, loc_quad;
  logic       busy, fe_busy;

  logic [3:0] tx_msg;
  logic       tx_vld, tx_pvld;
  logic [2:0] tx_rate;
  logic       tx_mode, tx_phase;
  logic [4:0] swing_lat;
  logic       resp_end, err_req;

  mbinit_param_responder #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .CLK                        (clk),
    .rst                        (rst),
    .i_MBINIT_Start_en          (start_en),
    .i_RX_SbMessage             (rx_msg),
    .i_msg_valid                (msg_valid),
    .i_RX_VoltageSwing          (rx_swing),
    .i_RX_MaxDataRate           (rx_rate),
    .i_RX_ClockMode             (rx_mode),
    .i_RX_PhaseClock            (rx_phase),
    .i_Local_MaxDataRate        (loc_rate),
    .i_Local_ContClk_Support    (loc_cont),
    .i_Local_Quad_Support       (loc_quad),
    .i_Busy_SideBand            (busy),
    .i_falling_edge_busy        (fe_busy),
    .o_TX_SbMessage             (tx_msg),
    .o_ValidOutDatat_Module     (tx_vld),
    .o_ValidDataFieldParameters (tx_pvld),
    .o_TX_MaxDataRate           (tx_rate),
    .o_TX_ClockMode             (tx_mode),
    .o_TX_PhaseClock            (tx_phase),
    .o_RX_VoltageSwing_Latched  (swing_lat),
    .o_MBINIT_PARAM_Resp_end    (resp_end),
    .o_train_error_req          (err_req)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected outputs.
  int exp_msg, exp_vld, exp_pvld, exp_rate, exp_mode, exp_phase, exp_swing, exp_end, exp_err;
  // Parameters of the most recently accepted req.
  int lat_rate, lat_mode, lat_phase;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_tx();
    exp_msg = 0; exp_vld = 0; exp_pvld = 0; exp_rate = 0; exp_mode = 0; exp_phase = 0;
  endtask

  task automatic clr_all();
    clr_tx();
    exp_swing = 0; exp_end = 0; exp_err = 0;
  endtask

  // Resp content: lower of the two rates, mode/phase only if supported locally.
  task automatic expect_resp();
    exp_msg   = 2;
    exp_vld   = 1;
    exp_pvld  = 1;
    exp_rate  = (lat_rate < int'(loc_rate)) ? lat_rate : int'(loc_rate);
    exp_mode  = lat_mode & int'(loc_cont);
    exp_phase = lat_phase & int'(loc_quad);
    exp_end   = 0;
  endtask

  // Present a req for one cycle; after the capture edge all outputs read 0 except the swing.
  task automatic send_req(input int r, input int m, input int p, input int s);
    rx_msg = 4'b0001; msg_valid = 1'b1;
    rx_rate = 3'(r); rx_mode = 1'(m); rx_phase = 1'(p); rx_swing = 5'(s);
    tick();
    msg_valid = 1'b0; rx_msg = 4'b0000;
    lat_rate = r; lat_mode = m; lat_phase = p;
    clr_tx(); exp_end = 0; exp_swing = s;
  endtask

  task automatic finish_send();
    busy = 1'b0; fe_busy = 1'b1;
    tick();
    fe_busy = 1'b0;
    clr_tx(); exp_end = 1;
  endtask

  task automatic drop_enable();
    start_en = 1'b0;
    tick();
    clr_all();
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx_msg",    int'(tx_msg),    exp_msg);
      chk("tx_valid",  int'(tx_vld),    exp_vld);
      chk("tx_pvalid", int'(tx_pvld),   exp_pvld);
      chk("tx_rate",   int'(tx_rate),   exp_rate);
      chk("tx_mode",   int'(tx_mode),   exp_mode);
      chk("tx_phase",  int'(tx_phase),  exp_phase);
      chk("swing",     int'(swing_lat), exp_swing);
      chk("resp_end",  int'(resp_end),  exp_end);
      chk("err_req",   int'(err_req),   exp_err);
    end
  end

  initial begin
    rst = 1'b1; start_en = 1'b0; rx_msg = '0; msg_valid = 1'b0;
    rx_swing = '0; rx_rate = '0; rx_mode = 1'b0; rx_phase = 1'b0;
    loc_rate = 3'd3; loc_cont = 1'b1; loc_quad = 1'b0;
    busy = 1'b0; fe_busy = 1'b0;
    lat_rate = 0; lat_mode = 0; lat_phase = 0;
    clr_all();
    chk_on = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Nominal exchange.
    start_en = 1'b1;
    tick();
    repeat (2) tick();
    send_req(5, 1, 1, 5'h15);
    tick();
    expect_resp();
    chk("nom_code_lit",  int'(tx_msg),   2);
    chk("nom_rate_lit",  int'(tx_rate),  3);
    chk("nom_mode_lit",  int'(tx_mode),  1);
    chk("nom_phase_lit", int'(tx_phase), 0);
    busy = 1'b1;
    repeat (3) tick();
    finish_send();
    chk("nom_end_lit", int'(resp_end), 1);
    repeat (2) tick();

    // Partner retry while DONE.
    send_req(2, 0, 1, 5'h0A);
    tick();
    expect_resp();
    chk("retry_rate_lit", int'(tx_rate), 2);
    finish_send();
    tick();
    drop_enable();
    tick();

    // Sideband busy delays the resp.
    start_en = 1'b1;
    tick();
    busy = 1'b1;
    send_req(5, 1, 1, 5'h11);
    repeat (10) tick();
    busy = 1'b0;
    tick();
    expect_resp();
    chk("busy_rate_lit", int'(tx_rate), 3);
    busy = 1'b1;
    tick();
    finish_send();

    // Abort in SEND_RESP.
    send_req(4, 0, 0, 5'h03);
    tick();
    expect_resp();
    busy = 1'b1;
    tick();
    drop_enable();
    busy = 1'b0;
    tick();

    // No common rate: one error pulse, then stuck until disabled.
    start_en = 1'b1;
    tick();
    send_req(0, 1, 1, 5'h07);
    tick();
    exp_err = 1;
    chk("nocr_err_lit", int'(err_req), 1);
    tick();
    exp_err = 0;
    rx_msg = 4'b0001; msg_valid = 1'b1; rx_rate = 3'd5; rx_swing = 5'h1C;
    tick();
    msg_valid = 1'b0; rx_msg = '0;
    fe_busy = 1'b1;
    tick();
    fe_busy = 1'b0;
    repeat (3) tick();
    drop_enable();
    tick();

    // Timeout with no req; a foreign code in the middle is ignored.
    start_en = 1'b1;
    tick();
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) begin rx_msg = 4'b0010; msg_valid = 1'b1; end
      tick();
      msg_valid = 1'b0; rx_msg = '0;
    end
    tick();
    exp_err = 1;
    chk("to_err_lit", int'(err_req), 1);
    tick();
    exp_err = 0;
    tick();
    drop_enable();

    // Req on the last timeout cycle wins.
    start_en = 1'b1;
    tick();
    repeat (15) tick();
    send_req(6, 1, 0, 5'h09);
    tick();
    expect_resp();
    chk("to_race_vld_lit", int'(tx_vld), 1);
    finish_send();
    drop_enable();

    // Asynchronous reset mid-transfer.
    start_en = 1'b1;
    tick();
    send_req(6, 1, 1, 5'h1F);
    tick();
    expect_resp();
    busy = 1'b1;
    #2;
    rst = 1'b1;
    clr_all();
    #1;
    chk("arst_vld_lit", int'(tx_vld), 0);
    chk("arst_msg_lit", int'(tx_msg), 0);
    busy = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    send_req(7, 0, 1, 5'h12);
    tick();
    expect_resp();
    chk("arst_after_rate_lit", int'(tx_rate), 3);
    finish_send();
    drop_enable();
    tick();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
